// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for window_gen and conv_block
//
// Holds the default image/kernel geometry, the counter widths derived from it,
// the KxK window type exchanged with conv_block, the window_gen FSM state enum
// and a counter-width helper usable with non-default geometries.
package conv_pkg;

  localparam int DEF_NBIT        = 8;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_IMG_WIDTH   = 640;
  localparam int DEF_IMG_HEIGHT  = 480;

  localparam int COL_W = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W = $clog2(DEF_IMG_HEIGHT);

  // [0][0] is the top-left (oldest) pixel, [K-1][K-1] the newest.
  typedef logic [DEF_NBIT-1:0] window_t [DEF_KERNEL_SIZE][DEF_KERNEL_SIZE];

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // Counter width for a coordinate range of n values; never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-row delay line feeding the sliding window
//
// Ports:
//   i_clk     clock
//   i_we      write enable (pixel accepted this cycle)
//   i_addr    column of the pixel being accepted
//   i_pixel   pixel to store at i_addr
//   o_pixel   pixel stored at i_addr one row earlier (read before write)
//
// Storage is deliberately not reset; the window generator masks rows whose
// history would still be stale.
module line_buffer #(
  parameter int NBIT  = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [NBIT-1:0] i_pixel,
  output logic [NBIT-1:0] o_pixel
);

  logic [NBIT-1:0] mem [DEPTH];

  // Combinational read returns the previous row's pixel for this column while
  // the same cycle overwrites it with the current row's pixel.
  assign o_pixel = mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= i_pixel;
    end
  end

endmodule

// File: rtl/window_gen.sv
// rtl/window_gen.sv - streaming KxK valid-region sliding-window generator
//
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_pixel         raster-order pixel
//   i_pixel_valid   pixel accepted this cycle (no backpressure)
//   i_sof           start of frame, qualified by i_pixel_valid
//   o_window        KxK window, [0][0] oldest/top-left, [K-1][K-1] newest
//   o_window_valid  one-cycle strobe: o_window is a complete valid-region window
//   o_frame_done    one-cycle strobe registered with the frame's last pixel
//   o_win_row       window centre row    (only with WINDOW_GEN_COORD_EN)
//   o_win_col       window centre column (only with WINDOW_GEN_COORD_EN)
//
// Optional feature macro: WINDOW_GEN_COORD_EN adds o_win_row/o_win_col.
module window_gen
  import conv_pkg::*;
#(
  parameter int NBIT        = DEF_NBIT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic [NBIT-1:0]                               i_pixel,
  input  logic                                          i_pixel_valid,
  input  logic                                          i_sof,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] o_window,
  output logic                                          o_window_valid,
`ifdef WINDOW_GEN_COORD_EN
  output logic [cnt_w(IMG_HEIGHT)-1:0]                  o_win_row,
  output logic [cnt_w(IMG_WIDTH)-1:0]                   o_win_col,
`endif
  output logic                                          o_frame_done
);

  localparam int K        = KERNEL_SIZE;
  localparam int COL_BITS = cnt_w(IMG_WIDTH);
  localparam int ROW_BITS = cnt_w(IMG_HEIGHT);

  localparam logic [COL_BITS-1:0] COL_FIRST = COL_BITS'(K - 1);
  localparam logic [ROW_BITS-1:0] ROW_FIRST = ROW_BITS'(K - 1);
  localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(IMG_HEIGHT - 1);

  state_e              state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d, cur_col;
  logic [ROW_BITS-1:0] row_q, row_d, cur_row;
  logic                accept;
  logic                last_px;
  logic                win_hit;

  logic [NBIT-1:0] lb_in  [K-1];
  logic [NBIT-1:0] lb_out [K-1];

  // Line buffer k delays by k+1 rows: each stage feeds on the previous one.
  for (genvar k = 0; k < K - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_in[k] = i_pixel;
    end else begin : g_chain
      assign lb_in[k] = lb_out[k-1];
    end

    line_buffer #(
      .NBIT  (NBIT),
      .DEPTH (IMG_WIDTH),
      .AW    (COL_BITS)
    ) u_line_buffer (
      .i_clk   (i_clk),
      .i_we    (accept),
      .i_addr  (cur_col),
      .i_pixel (lb_in[k]),
      .o_pixel (lb_out[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // A pixel with sof always becomes (0,0), whether the FSM is idle or the
  // current frame is being aborted; this also restarts row masking, so no
  // window mixing two frames can ever be flagged valid.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cur_col = col_q;
    cur_row = row_q;
    accept  = 1'b0;
    last_px = 1'b0;
    win_hit = 1'b0;

    if (i_pixel_valid && (i_sof || state_q == STREAM)) begin
      accept = 1'b1;
      if (i_sof) begin
        cur_col = '0;
        cur_row = '0;
      end
      last_px = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      win_hit = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);

      if (last_px) begin
        col_d   = '0;
        row_d   = '0;
        state_d = IDLE;
      end else if (cur_col == COL_LAST) begin
        col_d   = '0;
        row_d   = cur_row + 1'b1;
        state_d = STREAM;
      end else begin
        col_d   = cur_col + 1'b1;
        row_d   = cur_row;
        state_d = STREAM;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      o_window_valid <= accept && win_hit;
      o_frame_done   <= accept && last_px;
      if (accept) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) begin
            o_window[i][j] <= o_window[i][j+1];
          end
        end
        // Row i of the window is K-1-i rows old: line buffer K-2-i.
        for (int i = 0; i < K - 1; i++) begin
          o_window[i][K-1] <= lb_out[K-2-i];
        end
        o_window[K-1][K-1] <= i_pixel;
      end
    end
  end

`ifdef WINDOW_GEN_COORD_EN
  localparam logic [COL_BITS-1:0] COL_HALF = COL_BITS'(K / 2);
  localparam logic [ROW_BITS-1:0] ROW_HALF = ROW_BITS'(K / 2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_win_row <= '0;
      o_win_col <= '0;
    end else if (accept && win_hit) begin
      o_win_row <= cur_row - ROW_HALF;
      o_win_col <= cur_col - COL_HALF;
    end
  end
`endif

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - scoreboard bench for window_gen (W=5, H=4, K=3)
module tb_window_gen;

  localparam int NB = 8;
  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n;
  logic [NB-1:0]                 pixel;
  logic                          pvalid;
  logic                          sof;
  logic [K-1:0][K-1:0][NB-1:0]   win;
  logic                          wvalid;
  logic                          fdone;
`ifdef WINDOW_GEN_COORD_EN
  logic [1:0]                    win_row;
  logic [2:0]                    win_col;
`endif

  window_gen #(
    .NBIT        (NB),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pixel        (pixel),
    .i_pixel_valid  (pvalid),
    .i_sof          (sof),
    .o_window       (win),
    .o_window_valid (wvalid),
`ifdef WINDOW_GEN_COORD_EN
    .o_win_row      (win_row),
    .o_win_col      (win_col),
`endif
    .o_frame_done   (fdone)
  );

  typedef struct {
    logic [K-1:0][K-1:0][NB-1:0] w;
    bit                          done;
    int                          r;
    int                          c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk     = 0;
  int   n_fail    = 0;
  int   valid_cnt = 0;
  int   done_cnt  = 0;
  logic vld_at_edge = 1'b0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
    return base + 8'(r * 16 + c);
  endfunction

  always @(posedge clk) vld_at_edge <= pvalid;

  always @(negedge clk) begin
    if (wvalid) begin
      valid_cnt++;
      chk("valid_after_gap", 72'(vld_at_edge), 72'(1));
      if (q.size() == 0) begin
        chk("unexpected_window", 72'(1), 72'(0));
      end else begin
        mon_e = q.pop_front();
        chk("window", win, mon_e.w);
        chk("frame_done", 72'(fdone), 72'(mon_e.done));
`ifdef WINDOW_GEN_COORD_EN
        chk("win_row", 72'(win_row), 72'(mon_e.r));
        chk("win_col", 72'(win_col), 72'(mon_e.c));
`endif
      end
    end
    if (fdone) begin
      done_cnt++;
      chk("done_with_window", 72'(wvalid), 72'(1));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int r, input int c, input logic s, input logic [7:0] base, input bit push);
    exp_t e;
    pvalid = 1'b1;
    sof    = s;
    pixel  = pix(base, r, c);
    if (push && r >= K - 1 && c >= K - 1) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          e.w[i][j] = pix(base, r - (K - 1) + i, c - (K - 1) + j);
        end
      end
      e.done = (r == H - 1) && (c == W - 1);
      e.r    = r - K / 2;
      e.c    = c - K / 2;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    pvalid = 1'b0;
    sof    = 1'b0;
  endtask

  task automatic frame(input logic [7:0] base, input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r, c, (r == 0 && c == 0), base, 1'b1);
        if (gaps) idle(int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic seg_end(input int exp_valid, input int exp_done);
    idle(3);
    chk("valid_count", 72'(valid_cnt), 72'(exp_valid));
    chk("done_count", 72'(done_cnt), 72'(exp_done));
    chk("queue_drained", 72'(q.size()), 72'(0));
    valid_cnt = 0;
    done_cnt  = 0;
    q.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    pvalid = 1'b0;
    sof    = 1'b0;
    pixel  = '0;
    idle(3);
    chk("rst_window", win, 72'(0));
    chk("rst_valid", 72'(wvalid), 72'(0));
    chk("rst_done", 72'(fdone), 72'(0));
    rst_n = 1'b1;
    idle(1);

    // Back-to-back frame.
    frame(8'h00, 1'b0);
    seg_end(6, 1);

    // Same frame with random gaps.
    frame(8'h00, 1'b1);
    seg_end(6, 1);

    // Idle after last pixel: pixels without sof are dropped.
    for (int i = 0; i < 2 * W; i++) send(i / W, i % W, 1'b0, 8'h00, 1'b0);
    seg_end(0, 0);

    // Frame 1 aborted at (2,1), then a full frame 2 with different data.
    for (int i = 0; i < 2 * W + 2; i++) send(i / W, i % W, (i == 0), 8'h00, 1'b1);
    frame(8'h80, 1'b0);
    seg_end(6, 1);

    // Reset while the (2,3) window is on the outputs.
    for (int i = 0; i < 2 * W + 3; i++) send(i / W, i % W, (i == 0), 8'h00, 1'b1);
    send(2, 3, 1'b0, 8'h00, 1'b0);
    chk("pre_reset_valid", 72'(wvalid), 72'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_window", win, 72'(0));
    chk("async_rst_valid", 72'(wvalid), 72'(0));
    idle(2);
    rst_n = 1'b1;
    idle(1);
    seg_end(1, 0);

    // Fresh frame after reset.
    frame(8'h40, 1'b1);
    seg_end(6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Streaming KxK sliding-window generator that feeds conv_block.
- Takes a raster-order pixel stream of one pixel per clock when valid.
- Stores K-1 previous image rows in line buffers.
- Emits a full KxK window plus a one-cycle valid strobe whose layout matches conv_block's i_data/i_data_valid.
- Valid-region only: no border padding. Output is (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) windows per frame.

Parameters:
- NBIT, 8, pixel bit-width.
- KERNEL_SIZE, 3, window side K (K>=2).
- IMG_WIDTH, 640, pixels per row (>=K).
- IMG_HEIGHT, 480, rows per frame (>=K).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_pixel  input  NBIT  incoming pixel, raster order.
- i_pixel_valid  input  1  i_pixel accepted this cycle. No backpressure.
- i_sof  input  1  start of frame. Qualified by i_pixel_valid; marks the pixel as (row 0, col 0).
- o_window  output  NBIT x [K-1:0][K-1:0]  window; [0][0] top-left (oldest), [K-1][K-1] newest pixel.
- o_window_valid  output  1  o_window holds a complete valid-region window. Single-cycle pulse.
- o_frame_done  output  1  one-cycle pulse, registered with the last pixel (row H-1, col W-1) of the frame.

Behaviour:
- One clock, i_clk. Reset is asynchronous, active-low (i_rst_n). All state is reset on assertion.
- Reset values:
  - o_window all zeros.
  - o_window_valid=0, o_frame_done=0.
  - Column/row counters 0.
  - State IDLE.
- Line buffer contents are not reset. Rows < K-1 are masked from the output, so stale contents are never visible.
- FSM states:
  - IDLE: waiting for a pixel with i_sof=1. Pixels with valid but no sof are dropped.
  - STREAM: counting pixels.
  - IDLE->STREAM on valid&sof.
  - STREAM->IDLE on acceptance of pixel (H-1, W-1).
- Counters:
  - col is $clog2(IMG_WIDTH) bits; row is $clog2(IMG_HEIGHT) bits.
  - col increments per accepted pixel and wraps at W-1 to 0, incrementing row.
- Line buffers: K-1 chained delay lines, each IMG_WIDTH deep. For the pixel at column c, line buffer k outputs the pixel at column c from row-(k+1).
- Window shift, on each accepted pixel:
  - window[i][j] <= window[i][j+1] for j<K-1.
  - window[i][K-1] <= line buffer (K-2-i) output for i<K-1.
  - window[K-1][K-1] <= i_pixel.
- Valid generation:
  - o_window_valid is registered: 1 the cycle after acceptance of a pixel with row>=K-1 && col>=K-1, else 0.
  - Latency is 1 clock from pixel to window.
- Gaps: i_pixel_valid=0 holds all state, deasserts o_window_valid, and leaves o_window unchanged.
- i_sof in STREAM (early restart): the current frame is aborted silently, with no o_frame_done. Counters restart so that pixel is (0,0). No window straddling the abort is ever flagged valid.
- Row start: window columns carry the previous row's tail. This is masked because col<K-1.
- Reset mid-frame: return to IDLE, outputs cleared immediately (asynchronously). The next frame requires i_sof.

Optional Feature:
- Macro WINDOW_GEN_COORD_EN.
- When defined, adds two outputs, o_win_row ($clog2(IMG_HEIGHT) bits) and o_win_col ($clog2(IMG_WIDTH) bits):
  - They carry the image coordinates of the window centre (row-K/2, col-K/2 of the newest pixel).
  - They are registered alongside o_window_valid and reset to 0.
- When undefined, these ports and their registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package conv_pkg holds:
  - Constants COL_W=$clog2(IMG_WIDTH), ROW_W=$clog2(IMG_HEIGHT).
  - The window typedef (NBIT-wide KxK unpacked array) shared with conv_block.
  - The FSM state enum {IDLE, STREAM}.
- One sub-module, line_buffer: a single-row delay line with a pixel in, the same column of the previous row out, a write enable equal to accept, and depth IMG_WIDTH.
- window_gen instantiates K-1 line_buffer instances.

Test Plan:
- Reset, then sof frame with W=5, H=4, K=3, pixel=row*16+col:
  - First o_window_valid occurs 1 cycle after pixel 0x22.
  - That window is [0][0]=0x00, [1][1]=0x11, [2][2]=0x22, [0][2]=0x02, [2][0]=0x20.
  - Exactly 6 valid pulses per frame.
- Same frame with random 0-3 cycle i_pixel_valid gaps:
  - Identical window sequence.
  - o_window_valid never asserted during gaps.
- Last pixel 0x34:
  - o_frame_done pulses once, together with the final window ([2][2]=0x34).
  - FSM returns to IDLE; pixels without sof are then ignored (0 valid pulses).
- i_sof reasserted at pixel (2,1) of frame 1, followed by a full frame 2:
  - No o_frame_done for frame 1.
  - Frame 2 produces exactly 6 correct windows.
  - No window mixes frame 1 and frame 2 rows as valid.
- i_rst_n pulled low at pixel (2,3):
  - o_window=0 and o_window_valid=0 immediately.
  - After release, a fresh sof frame produces correct output.
- With WINDOW_GEN_COORD_EN defined:
  - First valid window reports o_win_row=1, o_win_col=1.
  - Last window reports o_win_row=2, o_win_col=3.
